// File: rtl/light_pkg.sv
// Shared definitions for the light scheduler slice.
//   MODE_* : 2-bit pattern request encoding carried on the mode bus
//   state_t: scheduler control states
package light_pkg;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/light_scheduler_if.sv
// Pattern request handshake between a requester and light_scheduler.
//   mode       : requested pattern (see light_pkg MODE_*)
//   mode_valid : request strobe
//   mode_ready : scheduler can accept a request this cycle
interface light_scheduler_if;

  logic [1:0] mode;
  logic       mode_valid;
  logic       mode_ready;

  modport master (output mode, output mode_valid, input mode_ready);
  modport slave  (input mode, input mode_valid, output mode_ready);

endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter with a terminal pulse.
//   clk, reset : clock and synchronous active-high reset (count -> 0)
//   load       : preset count to CYCLES-1 (wins over en)
//   en         : count down one per cycle, reloading after reaching 0
//   done       : high in the enabled cycle where the count is 0, i.e. the
//                CYCLES-th enabled cycle after a load
module cycle_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] count;

  assign done = en && (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LAST;
    end else if (en) begin
      count <= (count == '0) ? LAST : count - 1'b1;
    end
  end

endmodule

// File: rtl/light_scheduler.sv
// Sequencer for the PWM fade channels: drives each channel's fade direction
// according to the selected pattern (off/chase/bounce/blink), advancing on a
// dwell timer. Any pattern change first darkens all channels for a drain
// interval so fades from the old pattern finish before the new one starts.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mode request handshake (slave side)
//   on         : per-channel fade direction, bit i -> channel i
//   pos        : current pattern position
//   step       : pulse in the first cycle a new position/phase is visible
//   busy       : high while draining
module light_scheduler
  import light_pkg::*;
#(
  parameter int unsigned LEDS         = 6,
  parameter int unsigned DWELL_CYCLES = 8388608,
  parameter int unsigned DRAIN_CYCLES = 4194304
) (
  input  logic                    clk,
  input  logic                    reset,
  light_scheduler_if.slave        bus,
  output logic [LEDS-1:0]         on,
  output logic [$clog2(LEDS)-1:0] pos,
  output logic                    step,
  output logic                    busy
);

  localparam int unsigned PW = $clog2(LEDS);

  state_t        state;
  logic [1:0]    cur_mode;
  logic [1:0]    pend_mode;
  logic          dir;        // 1 = moving up
  logic          phase;      // blink phase, 1 = lit
  logic          mode_ready_q;

  logic          accept, start_run, change, resume;
  logic          dwell_done, drain_done;
  logic [PW-1:0] step_pos;
  logic          step_dir, step_phase;

  assign bus.mode_ready = mode_ready_q;

  assign accept    = bus.mode_valid && mode_ready_q;
  assign start_run = (state == IDLE) && accept && (bus.mode != MODE_OFF);
  assign change    = (state == RUN) && accept && (bus.mode != cur_mode);
  assign resume    = (state == DRAIN) && drain_done && (pend_mode != MODE_OFF);

  cycle_timer #(.CYCLES(DWELL_CYCLES)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .load  (start_run || resume),
    .en    (state == RUN),
    .done  (dwell_done)
  );

  cycle_timer #(.CYCLES(DRAIN_CYCLES)) u_drain (
    .clk   (clk),
    .reset (reset),
    .load  (change),
    .en    (state == DRAIN),
    .done  (drain_done)
  );

  function automatic logic [LEDS-1:0] pattern(input logic [1:0] m,
                                              input logic [PW-1:0] p,
                                              input logic ph);
    pattern = '0;
    case (m)
      MODE_CHASE, MODE_BOUNCE: pattern = LEDS'(1) << p;
      MODE_BLINK:              pattern = {LEDS{ph}};
      default:                 pattern = '0;
    endcase
  endfunction

  // Position/direction/phase that the next dwell terminal would produce.
  // Bounce flips direction as it arrives at an end, so the end is held for
  // one dwell only and the walk never repeats it.
  always_comb begin
    step_pos   = pos;
    step_dir   = dir;
    step_phase = phase;
    case (cur_mode)
      MODE_CHASE: step_pos = (pos == PW'(LEDS - 1)) ? '0 : pos + 1'b1;
      MODE_BOUNCE: begin
        if (dir) begin
          step_pos = pos + 1'b1;
          step_dir = (step_pos != PW'(LEDS - 1));
        end else begin
          step_pos = pos - 1'b1;
          step_dir = (step_pos == '0);
        end
      end
      MODE_BLINK: step_phase = ~phase;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cur_mode     <= MODE_OFF;
      pend_mode    <= MODE_OFF;
      on           <= '0;
      pos          <= '0;
      step         <= 1'b0;
      busy         <= 1'b0;
      mode_ready_q <= 1'b1;
      dir          <= 1'b1;
      phase        <= 1'b1;
    end else begin
      step <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_run) begin
            state    <= RUN;
            cur_mode <= bus.mode;
            pos      <= '0;
            dir      <= 1'b1;
            phase    <= 1'b1;
            on       <= pattern(bus.mode, '0, 1'b1);
          end
        end
        RUN: begin
          // A mode change outranks a coincident dwell terminal.
          if (change) begin
            state        <= DRAIN;
            pend_mode    <= bus.mode;
            on           <= '0;
            busy         <= 1'b1;
            mode_ready_q <= 1'b0;
          end else if (dwell_done) begin
            pos   <= step_pos;
            dir   <= step_dir;
            phase <= step_phase;
            on    <= pattern(cur_mode, step_pos, step_phase);
            step  <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state        <= (pend_mode == MODE_OFF) ? IDLE : RUN;
            cur_mode     <= pend_mode;
            pos          <= '0;
            dir          <= 1'b1;
            phase        <= 1'b1;
            on           <= pattern(pend_mode, '0, 1'b1);
            busy         <= 1'b0;
            mode_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
